riscboy_ppu_bus_responder: RTL
==============================

// Module: riscboy_ppu_bus_responder
// PURPOSE
//  Responder end of the PPU address/data read bus used by the PPU fetch units (tile AGU, pixel fetch).
//  - Accepts address-phase requests (addr_vld/addr_rdy, size, addr) and reads a W_MEM-wide synchronous memory port.
//  - Returns lane-extracted, zero-extended data strictly in order on bus_data_vld/bus_data.
//  - The requester has no data backpressure, so every accepted request yields exactly one data beat.
// PARAMETERS
//  W_ADDR       32          byte address width
//  W_DATA       16          requester data width (16 or 32)
//  W_MEM        32          memory data width (fixed 32)
//  MEM_LATENCY  1           cycles from mem issue (mem_ren && mem_gnt) to mem_rdata valid; 1..4
//  ADDR_MASK    32'hffffffff  applied to bus_addr before issue
// PORTS
//  clk            in   1         clock
//  rst_n          in   1         synchronous reset, active low
//  bus_addr_vld   in   1         request valid
//  bus_addr_rdy   out  1         request accepted when vld && rdy
//  bus_size       in   2         00 byte, 01 halfword, 10 word
//  bus_addr       in   W_ADDR    byte address
//  bus_data_vld   out  1         one-cycle pulse per response beat
//  bus_data       out  W_DATA    response data
//  mem_ren        out  1         memory read request
//  mem_gnt        in   1         memory accepts mem_ren this cycle
//  mem_addr       out  W_ADDR-2  word address = (bus_addr & ADDR_MASK) >> 2
//  mem_rdata      in   W_MEM     read data, valid MEM_LATENCY cycles after issue
//  busy           out  1         any request buffered or in flight
// BEHAVIOUR
//  - Reset (sync, rst_n low at clk edge): bus_data_vld=0, bus_data=0, busy=0, mem_ren=0; all in-flight tags cleared.
//    Responses for requests issued before reset are discarded. bus_addr_rdy=0 during reset.
//  - Issue path (default build):
//    - mem_ren=bus_addr_vld; mem_addr from bus_addr; bus_addr_rdy=mem_gnt (combinational).
//    - Accept == issue.
//  - Tag pipeline: MEM_LATENCY-deep shift register of {vld, size, addr[1:0]}, pushed on issue, shifted every cycle.
//  - Response register:
//    - When the tag reaches stage MEM_LATENCY, bus_data <= extract(mem_rdata) and bus_data_vld <= 1 on the next edge.
//    - Otherwise bus_data_vld <= 0 and bus_data holds its value.
//    - Latency from accept to bus_data_vld = MEM_LATENCY+1 cycles. Throughput 1 beat/cycle.
//  - Extraction:
//    - byte: lane addr[1:0], zero-extended.
//    - halfword: lane addr[1]; addr[0] ignored (misaligned treated as aligned down).
//    - word: mem_rdata[W_DATA-1:0]; addr[1:0] ignored.
//    - size 11: treated as word.
//  - Ordering: strictly in order. No reordering, no drops after accept.
//  - busy = issue-buffer nonempty OR any tag vld OR bus_data_vld pending.
//  - Back-to-back accepts every cycle with mem_gnt=1 must produce consecutive bus_data_vld pulses.
//  - mem_gnt low: holds requester (rdy=0). Tags already in flight still retire on schedule.
// CONFIGURATION
//  - RISCBOY_PPU_RESP_SKID_EN defined:
//    - Requests enter a 2-entry FIFO. bus_addr_rdy is registered: 1 when FIFO level after this cycle's push/pop is < 2.
//    - mem_ren = FIFO nonempty; pop on mem_gnt.
//    - Simultaneous push and pop at level 2 is not possible (rdy=0). Push and pop at level 1 keeps level 1.
//    - Latency from accept = MEM_LATENCY+2 cycles. Full throughput with mem_gnt held high.
//    - Reset empties the FIFO; bus_addr_rdy=0 in the reset cycle, 1 the cycle after.
//  - Undefined: combinational path as in the default issue path above, no FIFO.
// TESTING
//  1. MEM_LATENCY=1, byte read addr 0x102, mem word 0xAABBCCDD.
//     -> accept cycle 0; bus_data_vld cycle 2; bus_data=0x00BB.
//  2. Halfword reads at 0x200, 0x202, 0x203, back-to-back, mem word 0x12345678.
//     -> three consecutive pulses: 0x5678, 0x1234, 0x1234.
//  3. mem_gnt low for cycles 3-6 with vld held.
//     -> bus_addr_rdy=0 during 3-6; no accepts; earlier responses still arrive on time; busy=1 until last beat.
//  4. Reset asserted cycle 1 after accept at cycle 0 (MEM_LATENCY=2).
//     -> no bus_data_vld pulse ever; busy=0 after reset.
//  5. SKID_EN, mem_gnt=0, vld held high.
//     -> exactly 2 accepts, then rdy=0. Release mem_gnt: 2 beats in order, rdy=1 the following cycle.
//  6. Random stream of 1000 requests with random mem_gnt.
//     -> response count equals accept count; data matches model in order.

Source files
------------

// File: rtl/riscboy_ppu_bus_responder_if.sv
// Requester-side PPU read bus: address phase (vld/rdy, size, addr) and the unbackpressured data return.
interface riscboy_ppu_bus_responder_if #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 16
);
    logic              bus_addr_vld;
    logic              bus_addr_rdy;
    logic [1:0]        bus_size;
    logic [W_ADDR-1:0] bus_addr;
    logic              bus_data_vld;
    logic [W_DATA-1:0] bus_data;

    modport master (
        output bus_addr_vld, bus_size, bus_addr,
        input  bus_addr_rdy, bus_data_vld, bus_data
    );

    modport slave (
        input  bus_addr_vld, bus_size, bus_addr,
        output bus_addr_rdy, bus_data_vld, bus_data
    );
endinterface

// File: rtl/riscboy_ppu_bus_responder.sv
// PPU read-bus responder: issues reads to a fixed-latency memory port and returns lane-extracted data in order.
// Define RISCBOY_PPU_RESP_SKID_EN to put a 2-entry request FIFO (registered ready) in front of the memory port.
module riscboy_ppu_bus_responder #(
    parameter int unsigned       W_ADDR      = 32,
    parameter int unsigned       W_DATA      = 16,
    parameter int unsigned       W_MEM       = 32,
    parameter int unsigned       MEM_LATENCY = 1,
    parameter logic [W_ADDR-1:0] ADDR_MASK   = '1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    riscboy_ppu_bus_responder_if.slave bus,
    output logic                    mem_ren,
    input  logic                    mem_gnt,
    output logic [W_ADDR-3:0]       mem_addr,
    input  logic [W_MEM-1:0]        mem_rdata,
    output logic                    busy
);

    typedef struct packed {
        logic       vld;
        logic [1:0] size;
        logic [1:0] lane;
    } tag_t;

    logic              issue;
    logic [1:0]        iss_size;
    logic [W_ADDR-1:0] iss_addr;
    logic [W_ADDR-1:0] iss_addr_masked;
    logic              buf_nonempty;

`ifdef RISCBOY_PPU_RESP_SKID_EN
    // Two-entry request FIFO; ready is registered from the post-update level.
    logic [1:0]        fifo_size [2];
    logic [W_ADDR-1:0] fifo_addr [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        level;
    logic [1:0]        level_nxt;
    logic              rdy_q;
    logic              push;

    assign bus.bus_addr_rdy = rst_n && rdy_q;
    assign push             = bus.bus_addr_vld && bus.bus_addr_rdy;
    assign mem_ren          = rst_n && (level != 2'd0);
    assign issue            = mem_ren && mem_gnt;
    assign iss_size         = fifo_size[rd_ptr];
    assign iss_addr         = fifo_addr[rd_ptr];
    assign buf_nonempty     = (level != 2'd0);
    assign level_nxt        = level + 2'(push) - 2'(issue);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level        <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            rdy_q        <= 1'b1;
            fifo_size[0] <= 2'd0;
            fifo_size[1] <= 2'd0;
            fifo_addr[0] <= '0;
            fifo_addr[1] <= '0;
        end else begin
            level  <= level_nxt;
            rdy_q  <= (level_nxt < 2'd2);
            rd_ptr <= rd_ptr ^ issue;
            wr_ptr <= wr_ptr ^ push;
            if (push) begin
                fifo_size[wr_ptr] <= bus.bus_size;
                fifo_addr[wr_ptr] <= bus.bus_addr;
            end
        end
    end
`else
    // Pass-through issue: accept and memory issue are the same event.
    assign mem_ren          = rst_n && bus.bus_addr_vld;
    assign bus.bus_addr_rdy = rst_n && mem_gnt;
    assign issue            = mem_ren && mem_gnt;
    assign iss_size         = bus.bus_size;
    assign iss_addr         = bus.bus_addr;
    assign buf_nonempty     = 1'b0;
`endif

    assign iss_addr_masked = iss_addr & ADDR_MASK;
    assign mem_addr        = iss_addr_masked[W_ADDR-1:2];

    // Tag shift register: stage MEM_LATENCY-1 lines up with mem_rdata for its request.
    tag_t tag_q [MEM_LATENCY];
    tag_t tag_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: issue, size: iss_size, lane: iss_addr_masked[1:0]};
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_last = tag_q[MEM_LATENCY-1];

    // Lane extraction; misaligned halfwords round down, size 11 behaves as word.
    logic [W_DATA-1:0] ext_data;

    always_comb begin
        ext_data = '0;
        case (tag_last.size)
            2'b00:   ext_data = W_DATA'(mem_rdata[{tag_last.lane, 3'b000} +: 8]);
            2'b01:   ext_data = W_DATA'(tag_last.lane[1] ? mem_rdata[31:16] : mem_rdata[15:0]);
            default: ext_data = mem_rdata[W_DATA-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.bus_data_vld <= 1'b0;
            bus.bus_data     <= '0;
        end else begin
            bus.bus_data_vld <= tag_last.vld;
            if (tag_last.vld) begin
                bus.bus_data <= ext_data;
            end
        end
    end

    logic any_tag;

    always_comb begin
        any_tag = 1'b0;
        for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            any_tag = any_tag | tag_q[i].vld;
        end
    end

    assign busy = buf_nonempty || any_tag || bus.bus_data_vld;

endmodule
